// File: rtl/operand_sequencer.sv
// Operand sequencer: collects two operands from a byte stream, presents them
// to an external combinational adder, and holds the registered sum/carry
// until the downstream side accepts it. Counts completed result handshakes.
module operand_sequencer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] result,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  input  logic              out_ready,
  output logic [7:0]        op_count
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [DATA_W-1:0] sum_q,   sum_d;
  logic              carry_q, carry_d;
  logic              valid_q, valid_d;
  logic [7:0]        count_q, count_d;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      data1_q <= '0;
      data2_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d  = state_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    valid_d  = valid_q;
    count_d  = count_q;
    in_ready = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data1_d = in_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data2_d = in_data;
          state_d = CALC;
        end
      end
      CALC: begin
        // Modular sum wrapped below the first addend means a carry-out occurred.
        sum_d   = result;
        carry_d = (result < data1_q);
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 8'd1;
          state_d = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  assign data1     = data1_q;
  assign data2     = data2_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_valid = valid_q;
  assign op_count  = count_q;

endmodule
